lcd_bus_decoder: RTL and testbench

Receive-side decoder for the 8-bit 8080-style LCD write bus that `image_generator` drives (`wr`, `dcx`, `D[7:0]`). It sits on the same clock as the display path and stands in for the ILI9341-class panel. It interprets commands, tracks the column/page address window, assembles RGB565 pixels and emits one pixel per two data bytes with its screen coordinates. It is used as an on-chip monitor and as the bench-side model of the panel.

---
 rtl/lcd_pkg.sv | 18 +
 rtl/lcd_window_counter.sv | 26 ++
 rtl/lcd_bus_decoder.sv | 143 ++++++++++++++
 tb/tb_lcd_bus_decoder.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// lcd_pkg: LCD command codes and decoder states shared by the bus producer and decoder
package lcd_pkg;
   localparam logic [7:0] CMD_SWRESET = 8'h01;
   localparam logic [7:0] CMD_SLPIN   = 8'h10;
   localparam logic [7:0] CMD_SLPOUT  = 8'h11;
   localparam logic [7:0] CMD_DISPOFF = 8'h28;
   localparam logic [7:0] CMD_DISPON  = 8'h29;
   localparam logic [7:0] CMD_CASET   = 8'h2A;
   localparam logic [7:0] CMD_PASET   = 8'h2B;
   localparam logic [7:0] CMD_RAMWR   = 8'h2C;
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CASET  = 3'd1,
      ST_PASET  = 3'd2,
      ST_RAMWR  = 3'd3,
      ST_IGNORE = 3'd4
   } dec_state_t;
endpackage

// File: rtl/lcd_window_counter.sv
// lcd_window_counter: current write address with column/page wrap inside the address window
module lcd_window_counter (
   input  logic        clk,
   input  logic        nrst,
   input  logic        load,
   input  logic        adv,
   input  logic [15:0] xs,
   input  logic [15:0] xe,
   input  logic [15:0] ys,
   input  logic [15:0] ye,
   output logic [15:0] cur_x,
   output logic [15:0] cur_y
);
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         cur_x <= 16'd0;
         cur_y <= 16'd0;
      end else if (load) begin
         cur_x <= xs;
         cur_y <= ys;
      end else if (adv) begin
         cur_x <= (cur_x == xe) ? xs : cur_x + 16'd1;
         if (cur_x == xe) cur_y <= (cur_y == ye) ? ys : cur_y + 16'd1;
      end
   end
endmodule

// File: rtl/lcd_bus_decoder.sv
// lcd_bus_decoder: 8080-style LCD write-bus receiver emitting RGB565 pixels with coordinates
module lcd_bus_decoder
   import lcd_pkg::*;
#(
   parameter int H_RES = 320,
   parameter int V_RES = 240
) (
   input  logic        clk,
   input  logic        nrst,
   input  logic        wr,
   input  logic        dcx,
   input  logic [7:0]  d,
   output logic        pixel_valid,
   output logic [15:0] pixel_x,
   output logic [15:0] pixel_y,
   output logic [15:0] pixel_rgb,
   output logic        disp_on,
   output logic        awake,
   output logic        proto_err
);
   localparam logic [15:0] XE_RST = 16'(H_RES - 1);
   localparam logic [15:0] YE_RST = 16'(V_RES - 1);

   dec_state_t  state;
   logic        wr_q, odd;
   logic [1:0]  idx;
   logic [23:0] sh;
   logic [7:0]  hi;
   logic [15:0] xs, xe, ys, ye, cur_x, cur_y;
   logic [15:0] st_v, en_raw, en_v;
   logic        cmd, dat, load, adv;

   assign cmd    = wr & ~wr_q & ~dcx;
   assign dat    = wr & ~wr_q & dcx;
   assign load   = cmd && (d == CMD_RAMWR);
   assign adv    = dat && (state == ST_RAMWR) && odd;
   // the fourth shadow byte is the live bus byte, so commit needs no extra cycle
   assign st_v   = sh[23:8];
   assign en_raw = {sh[7:0], d};
   assign en_v   = (en_raw < st_v) ? st_v : en_raw;

   lcd_window_counter u_cnt (
      .clk   (clk),
      .nrst  (nrst),
      .load  (load),
      .adv   (adv),
      .xs    (xs),
      .xe    (xe),
      .ys    (ys),
      .ye    (ye),
      .cur_x (cur_x),
      .cur_y (cur_y)
   );

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         wr_q        <= 1'b0;
         state       <= ST_IDLE;
         idx         <= 2'd0;
         sh          <= 24'd0;
         hi          <= 8'd0;
         odd         <= 1'b0;
         xs          <= 16'd0;
         xe          <= XE_RST;
         ys          <= 16'd0;
         ye          <= YE_RST;
         pixel_valid <= 1'b0;
         pixel_x     <= 16'd0;
         pixel_y     <= 16'd0;
         pixel_rgb   <= 16'd0;
         disp_on     <= 1'b0;
         awake       <= 1'b0;
         proto_err   <= 1'b0;
      end else begin
         wr_q        <= wr;
         pixel_valid <= 1'b0;
         proto_err   <= cmd & ((state == ST_CASET) || (state == ST_PASET) || ((state == ST_RAMWR) && odd));
         if (cmd) begin
            idx <= 2'd0;
            odd <= 1'b0;
            case (d)
               CMD_CASET: state <= ST_CASET;
               CMD_PASET: state <= ST_PASET;
               CMD_RAMWR: state <= ST_RAMWR;
               CMD_SWRESET: begin
                  state   <= ST_IDLE;
                  xs      <= 16'd0;
                  xe      <= XE_RST;
                  ys      <= 16'd0;
                  ye      <= YE_RST;
                  disp_on <= 1'b0;
                  awake   <= 1'b0;
               end
               CMD_SLPIN: begin
                  state <= ST_IDLE;
                  awake <= 1'b0;
               end
               CMD_SLPOUT: begin
                  state <= ST_IDLE;
                  awake <= 1'b1;
               end
               CMD_DISPOFF: begin
                  state   <= ST_IDLE;
                  disp_on <= 1'b0;
               end
               CMD_DISPON: begin
                  state   <= ST_IDLE;
                  disp_on <= 1'b1;
               end
               default: state <= ST_IGNORE;
            endcase
         end else if (dat) begin
            case (state)
               ST_CASET, ST_PASET: begin
                  idx <= idx + 2'd1;
                  sh  <= {sh[15:0], d};
                  if (idx == 2'd3) begin
                     state <= ST_IDLE;
                     if (state == ST_CASET) begin
                        xs <= st_v;
                        xe <= en_v;
                     end else begin
                        ys <= st_v;
                        ye <= en_v;
                     end
                  end
               end
               ST_RAMWR: begin
                  odd <= ~odd;
                  if (!odd) hi <= d;
                  if (odd) begin
                     pixel_valid <= 1'b1;
                     pixel_x     <= cur_x;
                     pixel_y     <= cur_y;
                     pixel_rgb   <= {hi, d};
                  end
               end
               default: ;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_lcd_bus_decoder.sv
// tb_lcd_bus_decoder: directed and randomized bus traffic checked against a pixel-index window model
module tb_lcd_bus_decoder;
   logic        clk = 1'b0;
   logic        nrst, wr, dcx;
   logic [7:0]  d;
   logic        pixel_valid, disp_on, awake, proto_err;
   logic [15:0] pixel_x, pixel_y, pixel_rgb;

   int total = 0;
   int bad = 0;

   logic [47:0] got[$];
   logic [47:0] exp_q[$];
   int          got_err, exp_err;

   int          m_mode, m_xs, m_xe, m_ys, m_ye, m_n;
   logic [7:0]  m_sh[$];
   bit          m_hv, m_disp, m_awake;
   logic [7:0]  m_hi;

   logic [7:0]  cmds [10] = '{8'h2A, 8'h2B, 8'h2C, 8'h2C, 8'h01, 8'h10, 8'h11, 8'h28, 8'h29, 8'h36};

   always #5 clk = ~clk;

   lcd_bus_decoder dut (
      .clk         (clk),
      .nrst        (nrst),
      .wr          (wr),
      .dcx         (dcx),
      .d           (d),
      .pixel_valid (pixel_valid),
      .pixel_x     (pixel_x),
      .pixel_y     (pixel_y),
      .pixel_rgb   (pixel_rgb),
      .disp_on     (disp_on),
      .awake       (awake),
      .proto_err   (proto_err)
   );

   always @(negedge clk) begin
      if (pixel_valid) got.push_back({pixel_x, pixel_y, pixel_rgb});
      if (proto_err) got_err++;
   end

   function automatic void model_reset();
      m_mode = 0; m_xs = 0; m_xe = 319; m_ys = 0; m_ye = 239; m_n = 0;
      m_sh.delete(); m_hv = 0; m_disp = 0; m_awake = 0;
   endfunction

   // expected pixel position is the pixel ordinal folded over the window size
   function automatic void model_byte(input bit c, input logic [7:0] v);
      int s, e, w, h, x, y;
      if (!c) begin
         if (m_mode == 1 || m_mode == 2 || (m_mode == 3 && m_hv)) exp_err++;
         m_sh.delete();
         m_hv = 0;
         case (v)
            8'h2A: m_mode = 1;
            8'h2B: m_mode = 2;
            8'h2C: begin m_mode = 3; m_n = 0; end
            8'h01: begin m_mode = 0; m_xs = 0; m_xe = 319; m_ys = 0; m_ye = 239; m_disp = 0; m_awake = 0; end
            8'h10: begin m_mode = 0; m_awake = 0; end
            8'h11: begin m_mode = 0; m_awake = 1; end
            8'h28: begin m_mode = 0; m_disp = 0; end
            8'h29: begin m_mode = 0; m_disp = 1; end
            default: m_mode = 4;
         endcase
      end else if (m_mode == 1 || m_mode == 2) begin
         m_sh.push_back(v);
         if (m_sh.size() == 4) begin
            s = int'(m_sh[0]) * 256 + int'(m_sh[1]);
            e = int'(m_sh[2]) * 256 + int'(m_sh[3]);
            if (e < s) e = s;
            if (m_mode == 1) begin m_xs = s; m_xe = e; end
            else begin m_ys = s; m_ye = e; end
            m_mode = 0;
            m_sh.delete();
         end
      end else if (m_mode == 3) begin
         if (!m_hv) begin
            m_hi = v;
            m_hv = 1;
         end else begin
            w = m_xe - m_xs + 1;
            h = m_ye - m_ys + 1;
            x = m_xs + m_n % w;
            y = m_ys + (m_n / w) % h;
            exp_q.push_back({16'(x), 16'(y), m_hi, v});
            m_n++;
            m_hv = 0;
         end
      end
   endfunction

   task automatic send_byte(input bit c, input logic [7:0] v, input int lo, input int hi);
      wr = 1'b0; dcx = c; d = v;
      repeat (lo) @(negedge clk);
      wr = 1'b1;
      repeat (hi) @(negedge clk);
      model_byte(c, v);
   endtask

   task automatic cmd(input logic [7:0] v);
      send_byte(1'b0, v, 1, 1);
   endtask

   task automatic dat(input logic [7:0] v);
      send_byte(1'b1, v, 1, 1);
   endtask

   task automatic start_test();
      got.delete(); exp_q.delete(); got_err = 0; exp_err = 0;
   endtask

   task automatic test_reset();
      nrst = 1'b0; wr = 1'b0; dcx = 1'b0; d = 8'h00;
      model_reset();
      repeat (3) @(negedge clk);
      nrst = 1'b1;
      @(negedge clk);
      total++; if (pixel_valid !== 1'b0) begin bad++; $display("FAIL reset pixel_valid got=%b exp=0", pixel_valid); end
      total++; if (pixel_x !== 16'd0) begin bad++; $display("FAIL reset pixel_x got=%h exp=0", pixel_x); end
      total++; if (pixel_y !== 16'd0) begin bad++; $display("FAIL reset pixel_y got=%h exp=0", pixel_y); end
      total++; if (pixel_rgb !== 16'd0) begin bad++; $display("FAIL reset pixel_rgb got=%h exp=0", pixel_rgb); end
      total++; if (disp_on !== 1'b0) begin bad++; $display("FAIL reset disp_on got=%b exp=0", disp_on); end
      total++; if (awake !== 1'b0) begin bad++; $display("FAIL reset awake got=%b exp=0", awake); end
      total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL reset proto_err got=%b exp=0", proto_err); end
   endtask

   task automatic test_basic();
      start_test();
      cmd(8'h2C); dat(8'hF8); dat(8'h00); dat(8'h07); dat(8'hE0);
      repeat (2) @(negedge clk);
      total++; if (exp_q.size() != 2) begin bad++; $display("FAIL basic model_npix got=%0d exp=2", exp_q.size()); end
      total++; if (got.size() != exp_q.size()) begin bad++; $display("FAIL basic npix got=%0d exp=%0d", got.size(), exp_q.size()); end
      foreach (exp_q[i]) begin total++; if (i >= got.size() || got[i] !== exp_q[i]) begin bad++; $display("FAIL basic pix%0d got=%h exp=%h", i, (i < got.size()) ? got[i] : 48'hx, exp_q[i]); end end
      total++; if (disp_on !== 1'b0) begin bad++; $display("FAIL basic disp_on got=%b exp=0", disp_on); end
   endtask

   task automatic test_window();
      start_test();
      cmd(8'h2A); dat(8'h00); dat(8'd10); dat(8'h00); dat(8'd11);
      cmd(8'h2B); dat(8'h00); dat(8'd5); dat(8'h00); dat(8'd6);
      cmd(8'h2C);
      for (int i = 0; i < 10; i++) dat(8'($urandom));
      repeat (2) @(negedge clk);
      total++; if (got.size() != exp_q.size()) begin bad++; $display("FAIL window npix got=%0d exp=%0d", got.size(), exp_q.size()); end
      foreach (exp_q[i]) begin total++; if (i >= got.size() || got[i] !== exp_q[i]) begin bad++; $display("FAIL window pix%0d got=%h exp=%h", i, (i < got.size()) ? got[i] : 48'hx, exp_q[i]); end end
      total++; if (got_err != 0) begin bad++; $display("FAIL window proto_err got=%0d exp=0", got_err); end
   endtask

   task automatic test_short_caset();
      start_test();
      cmd(8'h2A); dat(8'h00); dat(8'h03);
      cmd(8'h2C); dat(8'h12); dat(8'h34);
      repeat (2) @(negedge clk);
      total++; if (got_err != exp_err) begin bad++; $display("FAIL short_caset proto_err got=%0d exp=%0d", got_err, exp_err); end
      total++; if (got.size() != exp_q.size()) begin bad++; $display("FAIL short_caset npix got=%0d exp=%0d", got.size(), exp_q.size()); end
      foreach (exp_q[i]) begin total++; if (i >= got.size() || got[i] !== exp_q[i]) begin bad++; $display("FAIL short_caset pix%0d got=%h exp=%h", i, (i < got.size()) ? got[i] : 48'hx, exp_q[i]); end end
   endtask

   task automatic test_abort();
      start_test();
      cmd(8'h2C); dat(8'hAB); dat(8'hCD); dat(8'hEF);
      cmd(8'h29);
      total++; if (disp_on !== 1'b1) begin bad++; $display("FAIL abort disp_on got=%b exp=1", disp_on); end
      repeat (2) @(negedge clk);
      total++; if (got_err != exp_err || exp_err != 1) begin bad++; $display("FAIL abort proto_err got=%0d exp=%0d", got_err, exp_err); end
      total++; if (got.size() != exp_q.size()) begin bad++; $display("FAIL abort npix got=%0d exp=%0d", got.size(), exp_q.size()); end
      foreach (exp_q[i]) begin total++; if (i >= got.size() || got[i] !== exp_q[i]) begin bad++; $display("FAIL abort pix%0d got=%h exp=%h", i, (i < got.size()) ? got[i] : 48'hx, exp_q[i]); end end
   endtask

   task automatic test_wr_hold();
      start_test();
      cmd(8'h2C);
      send_byte(1'b1, 8'h12, 1, 5); dat(8'h34);
      send_byte(1'b1, 8'h56, 2, 5); send_byte(1'b1, 8'h78, 1, 5);
      repeat (2) @(negedge clk);
      total++; if (got.size() != exp_q.size()) begin bad++; $display("FAIL wr_hold npix got=%0d exp=%0d", got.size(), exp_q.size()); end
      foreach (exp_q[i]) begin total++; if (i >= got.size() || got[i] !== exp_q[i]) begin bad++; $display("FAIL wr_hold pix%0d got=%h exp=%h", i, (i < got.size()) ? got[i] : 48'hx, exp_q[i]); end end
   endtask

   task automatic test_reset_mid();
      start_test();
      cmd(8'h11); cmd(8'h2C); dat(8'h5A); dat(8'hA5); dat(8'h77);
      #2 nrst = 1'b0; wr = 1'b0;
      #1;
      total++; if ({pixel_valid, pixel_x, pixel_y, pixel_rgb, disp_on, awake, proto_err} !== 52'd0) begin bad++; $display("FAIL reset_mid outputs got=%b_%h_%h_%h_%b%b%b exp=all zero", pixel_valid, pixel_x, pixel_y, pixel_rgb, disp_on, awake, proto_err); end
      model_reset();
      repeat (3) @(negedge clk);
      nrst = 1'b1;
      got.delete(); exp_q.delete(); got_err = 0; exp_err = 0;
      dat(8'h88);
      repeat (2) @(negedge clk);
      total++; if (got.size() != 0) begin bad++; $display("FAIL reset_mid npix got=%0d exp=0", got.size()); end
      total++; if (awake !== 1'b0) begin bad++; $display("FAIL reset_mid awake got=%b exp=0", awake); end
   endtask

   task automatic test_inverted();
      start_test();
      cmd(8'h2A); dat(8'h00); dat(8'd20); dat(8'h00); dat(8'd5);
      cmd(8'h2C);
      for (int i = 0; i < 6; i++) dat(8'(i + 1));
      repeat (2) @(negedge clk);
      total++; if (got.size() != 3) begin bad++; $display("FAIL inverted npix got=%0d exp=3", got.size()); end
      foreach (exp_q[i]) begin total++; if (i >= got.size() || got[i] !== exp_q[i]) begin bad++; $display("FAIL inverted pix%0d got=%h exp=%h", i, (i < got.size()) ? got[i] : 48'hx, exp_q[i]); end end
   endtask

   task automatic test_back_to_back();
      start_test();
      cmd(8'h2A); dat(8'h00); dat(8'h00); dat(8'h00); dat(8'h01);
      cmd(8'h2B); dat(8'h00); dat(8'h03); dat(8'h00); dat(8'h04);
      cmd(8'h2C);
      for (int i = 0; i < 18; i++) dat(8'($urandom));
      repeat (2) @(negedge clk);
      total++; if (got.size() != exp_q.size()) begin bad++; $display("FAIL b2b npix got=%0d exp=%0d", got.size(), exp_q.size()); end
      foreach (exp_q[i]) begin total++; if (i >= got.size() || got[i] !== exp_q[i]) begin bad++; $display("FAIL b2b pix%0d got=%h exp=%h", i, (i < got.size()) ? got[i] : 48'hx, exp_q[i]); end end
   endtask

   task automatic test_random();
      logic [7:0] v;
      start_test();
      for (int k = 0; k < 600; k++) begin
         if ($urandom_range(0, 9) == 0) begin
            send_byte(1'b0, cmds[$urandom_range(0, 9)], $urandom_range(1, 3), $urandom_range(1, 3));
         end else begin
            v = $urandom_range(0, 1) ? 8'($urandom_range(0, 7)) : 8'($urandom);
            send_byte(1'b1, v, $urandom_range(1, 3), $urandom_range(1, 3));
         end
      end
      repeat (2) @(negedge clk);
      total++; if (got.size() != exp_q.size()) begin bad++; $display("FAIL random npix got=%0d exp=%0d", got.size(), exp_q.size()); end
      foreach (exp_q[i]) begin total++; if (i >= got.size() || got[i] !== exp_q[i]) begin bad++; $display("FAIL random pix%0d got=%h exp=%h", i, (i < got.size()) ? got[i] : 48'hx, exp_q[i]); end end
      total++; if (got_err != exp_err) begin bad++; $display("FAIL random proto_err got=%0d exp=%0d", got_err, exp_err); end
      total++; if (disp_on !== m_disp) begin bad++; $display("FAIL random disp_on got=%b exp=%b", disp_on, m_disp); end
      total++; if (awake !== m_awake) begin bad++; $display("FAIL random awake got=%b exp=%b", awake, m_awake); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_window();
      test_short_caset();
      test_abort();
      test_wr_hold();
      test_reset_mid();
      test_inverted();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
